// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - SimpleCPU multi-cycle control unit
// Holds PC/IR and sequences FETCH, DECODE and one execute cycle per instruction.
module cpu_controller #(
    parameter int PC_W = 8,
    parameter int D_W  = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    output logic [PC_W-1:0] I_addr,
    output logic            I_rd,
    input  logic [15:0]     I_data,
    output logic [D_W-1:0]  D_addr,
    output logic            D_rd,
    output logic            D_wr,
    output logic            RF_s1,
    output logic            RF_s0,
    output logic [3:0]      RF_W_addr,
    output logic            RF_W_wr,
    output logic [3:0]      RF_Rp_addr,
    output logic            RF_Rp_rd,
    output logic [3:0]      RF_Rq_addr,
    output logic            RF_Rq_rd,
    output logic            alu_s1,
    output logic            alu_s0,
    output logic [7:0]      RF_W_data,
    input  logic            RF_Rp_zero,
    output logic            halted
);

    typedef enum logic [3:0] {
        ST_INIT   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_LOAD   = 4'd3,
        ST_STORE  = 4'd4,
        ST_ADD    = 4'd5,
        ST_LOADC  = 4'd6,
        ST_SUB    = 4'd7,
        ST_JMPZ   = 4'd8,
        ST_HALT   = 4'd9
    } state_t;

    localparam logic [3:0] OP_LOAD  = 4'h0;
    localparam logic [3:0] OP_STORE = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_LOADC = 4'h3;
    localparam logic [3:0] OP_SUB   = 4'h4;
    localparam logic [3:0] OP_JMPZ  = 4'h5;
    localparam logic [3:0] OP_HALT  = 4'hF;

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [15:0]     ir_q, ir_d;

    logic [3:0]      op, ra, rb, rc;
    logic [7:0]      imm;
    logic [PC_W-1:0] off_ext;

    assign op      = ir_q[15:12];
    assign ra      = ir_q[11:8];
    assign rb      = ir_q[7:4];
    assign rc      = ir_q[3:0];
    assign imm     = ir_q[7:0];
    // Jump offset is a signed byte, relative to the jump's own address.
    assign off_ext = PC_W'($signed(imm));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_INIT;
            pc_q    <= '0;
            ir_q    <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            ir_q    <= ir_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ir_d       = ir_q;
        I_addr     = pc_q;
        I_rd       = 1'b0;
        D_addr     = '0;
        D_rd       = 1'b0;
        D_wr       = 1'b0;
        RF_s1      = 1'b0;
        RF_s0      = 1'b0;
        RF_W_addr  = 4'd0;
        RF_W_wr    = 1'b0;
        RF_Rp_addr = 4'd0;
        RF_Rp_rd   = 1'b0;
        RF_Rq_addr = 4'd0;
        RF_Rq_rd   = 1'b0;
        alu_s1     = 1'b0;
        alu_s0     = 1'b0;
        RF_W_data  = 8'd0;
        halted     = 1'b0;

        case (state_q)
            ST_INIT: begin
                if (start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                I_rd    = 1'b1;
                ir_d    = I_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                case (op)
                    OP_LOAD:  state_d = ST_LOAD;
                    OP_STORE: state_d = ST_STORE;
                    OP_ADD:   state_d = ST_ADD;
                    OP_LOADC: state_d = ST_LOADC;
                    OP_SUB:   state_d = ST_SUB;
                    OP_JMPZ:  state_d = ST_JMPZ;
                    OP_HALT:  state_d = ST_HALT;
                    default:  state_d = ST_FETCH;
                endcase
            end
            ST_LOAD: begin
                D_addr    = D_W'(imm);
                D_rd      = 1'b1;
                RF_s0     = 1'b1;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_STORE: begin
                D_addr     = D_W'(imm);
                D_wr       = 1'b1;
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_ADD, ST_SUB: begin
                RF_Rp_addr = rb;
                RF_Rp_rd   = 1'b1;
                RF_Rq_addr = rc;
                RF_Rq_rd   = 1'b1;
                alu_s0     = (state_q == ST_ADD);
                alu_s1     = (state_q == ST_SUB);
                RF_W_addr  = ra;
                RF_W_wr    = 1'b1;
                state_d    = ST_FETCH;
            end
            ST_LOADC: begin
                RF_s1     = 1'b1;
                RF_W_data = imm;
                RF_W_addr = ra;
                RF_W_wr   = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_JMPZ: begin
                RF_Rp_addr = ra;
                RF_Rp_rd   = 1'b1;
                // PC already points past the jump, so step back one first.
                if (RF_Rp_zero) pc_d = pc_q - PC_W'(1) + off_ext;
                state_d = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_INIT;
            end
        endcase
    end

endmodule
